// File: rtl/mem_arbiter.sv
// Four-master round-robin arbiter and sequencer for a single-port node memory.
// Each master issues one word read or write per req/ack handshake; all outputs are registered.
module mem_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      nrst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          wr_req,
    input  logic [N_REQ*ADDR_W-1:0]   addr_bus,
    input  logic [N_REQ*DATA_W-1:0]   wdata_bus,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_address,
    output logic                      mem_wr_en,
    output logic [DATA_W-1:0]         mem_data_in,
    input  logic [DATA_W-1:0]         mem_data_out
);

    localparam int IDX_W = 2;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   ack_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               busy_q;
    logic [ADDR_W-1:0]  mem_address_q;
    logic               mem_wr_en_q;
    logic [DATA_W-1:0]  mem_data_in_q;
    logic [IDX_W-1:0]   last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               wr_op_q;

    logic [ADDR_W-1:0]  addr_arr [N_REQ];
    logic [DATA_W-1:0]  wdata_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_bus[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata_bus[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan from lowest to highest priority so the last hit is the one just after last_q.
    logic             pick_vld_d;
    logic [IDX_W-1:0] pick_idx_d;
    logic [IDX_W-1:0] cand;

    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        cand       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = last_q + IDX_W'(k);
            if (req[cand]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            ack_q         <= '0;
            rdata_q       <= '0;
            busy_q        <= 1'b0;
            mem_address_q <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_data_in_q <= '0;
            last_q        <= IDX_W'(N_REQ - 1);
            cnt_q         <= '0;
            wr_op_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        state_q       <= S_ACCESS;
                        gnt_q         <= N_REQ'(1) << pick_idx_d;
                        last_q        <= pick_idx_d;
                        busy_q        <= 1'b1;
                        wr_op_q       <= wr_req[pick_idx_d];
                        mem_wr_en_q   <= wr_req[pick_idx_d];
                        mem_address_q <= addr_arr[pick_idx_d];
                        mem_data_in_q <= wdata_arr[pick_idx_d];
                    end
                end
                S_ACCESS: begin
                    mem_wr_en_q <= 1'b0;
                    if (wr_op_q) begin
                        state_q <= S_DONE;
                        ack_q   <= gnt_q;
                    end else begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_W'(RD_LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q <= mem_data_out;
                        state_q <= S_DONE;
                        ack_q   <= gnt_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign mem_address = mem_address_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_data_in = mem_data_in_q;

endmodule
